// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module   : instr_fetch_if
// Purpose  : Instruction-memory request/acknowledge bus between the fetch
//            stage (master) and instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input  ack, rdata);
  modport slave  (input  req, addr, output ack, rdata);
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : Fetch stage: PC, req/ack instruction-memory handshake, instruction
//            register with stall and redirect (including redirect mid-request).
//            Optional IF_FETCH_COUNT_EN adds a 16-bit accepted-fetch counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               enable,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  instr_fetch_if.master      imem,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic [1:0]         op2,
  output logic [2:0]         op3,
  output logic [1:0]         fn2,
  output logic [2:0]         fn3
`ifdef IF_FETCH_COUNT_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pendingPc;
  logic              r_kill;

  // Decode fields are raw slices; the controller qualifies them with instr_valid.
  assign op2 = instr[18:17];
  assign op3 = instr[18:16];
  assign fn2 = instr[15:14];
  assign fn3 = instr[16:14];

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_pendingPc <= '0;
      r_kill      <= 1'b0;
      imem.req    <= 1'b0;
      imem.addr   <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
`ifdef IF_FETCH_COUNT_EN
      fetch_count <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect) begin
            r_pc        <= redirect_pc;
            instr_valid <= 1'b0;
          end else if (enable) begin
            imem.req  <= 1'b1;
            imem.addr <= r_pc;
            r_state   <= S_REQ;
          end
        end

        S_REQ: begin
          if (imem.ack) begin
            imem.req <= 1'b0;
            if (r_kill || redirect) begin
              // A same-cycle redirect is newer than any remembered target.
              r_pc    <= redirect ? redirect_pc : r_pendingPc;
              r_kill  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              instr       <= imem.rdata;
              instr_pc    <= imem.addr;
              instr_valid <= 1'b1;
              r_pc        <= r_pc + ADDR_W'(1);
              r_state     <= S_HOLD;
`ifdef IF_FETCH_COUNT_EN
              fetch_count <= fetch_count + 16'd1;
`endif
            end
          end else if (redirect) begin
            // The bus cannot be abandoned; finish it and drop the data.
            r_kill      <= 1'b1;
            r_pendingPc <= redirect_pc;
          end
        end

        S_HOLD: begin
          if (redirect) begin
            r_pc        <= redirect_pc;
            instr_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            if (enable) begin
              imem.req  <= 1'b1;
              imem.addr <= r_pc;
              r_state   <= S_REQ;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch: directed scenarios plus random
//            traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic [18:0] instr;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic [1:0]  op2, fn2;
  logic [2:0]  op3, fn3;
`ifdef IF_FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  instr_fetch_if #(.ADDR_W(12), .INSTR_W(19)) imem ();

  instr_fetch #(.ADDR_W(12), .INSTR_W(19)) dut (
    .clock       (clock),
    .rst         (rst),
    .enable      (enable),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem.master),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .op2         (op2),
    .op3         (op3),
    .fn2         (fn2),
    .fn3         (fn3)
`ifdef IF_FETCH_COUNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: an outstanding bus transaction, a held instruction, and
  // a remembered redirect target for a transaction that must be thrown away.
  bit          m_busy, m_have, m_kill;
  logic [11:0] m_pc, m_addr, m_pend, m_ipc;
  logic [18:0] m_instr;
  int          m_cnt;
  int          lat;   // memory wait cycles before ack
  int          wc;    // cycles the current request has been visible

  function automatic logic [18:0] tagOf(input logic [11:0] a);
    return {a[6:0] ^ 7'h55, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit en, input bit st, input bit rd,
                      input logic [11:0] rpc, input bit r);
    bit   ack;
    bit   wasBusy;
    logic [18:0] slice;
    ack     = m_busy && (wc >= lat);
    wasBusy = m_busy;
    rst         = r;
    enable      = en;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem.ack    = ack;
    imem.rdata  = ack ? tagOf(m_addr) : 19'($urandom);

    if (r) begin
      m_busy = 0; m_have = 0; m_kill = 0;
      m_pc = '0; m_addr = '0; m_pend = '0; m_ipc = '0; m_instr = '0; m_cnt = 0;
    end else if (m_busy) begin
      if (ack) begin
        m_busy = 0;
        if (m_kill || rd) begin
          m_pc   = rd ? rpc : m_pend;
          m_kill = 0;
        end else begin
          m_instr = tagOf(m_addr);
          m_ipc   = m_addr;
          m_have  = 1;
          m_pc    = m_pc + 12'd1;
          m_cnt   = (m_cnt + 1) % 65536;
        end
      end else if (rd) begin
        m_kill = 1;
        m_pend = rpc;
      end
    end else if (rd) begin
      m_have = 0;
      m_pc   = rpc;
    end else if (!(m_have && st)) begin
      m_have = 0;
      if (en) begin
        m_busy = 1;
        m_addr = m_pc;
      end
    end
    wc = (ack || !wasBusy || r) ? 0 : wc + 1;

    @(posedge clock);
    #1;
    slice = m_instr;
    chk("imem_req",    32'(imem.req),    32'(m_busy));
    chk("imem_addr",   32'(imem.addr),   32'(m_addr));
    chk("instr_valid", 32'(instr_valid), 32'(m_have));
    chk("instr",       32'(instr),       32'(m_instr));
    chk("instr_pc",    32'(instr_pc),    32'(m_ipc));
    chk("op2",         32'(op2),         32'(slice[18:17]));
    chk("op3",         32'(op3),         32'(slice[18:16]));
    chk("fn2",         32'(fn2),         32'(slice[15:14]));
    chk("fn3",         32'(fn3),         32'(slice[16:14]));
`ifdef IF_FETCH_COUNT_EN
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
`endif
  endtask

  // Let everything finish with enable low so the next scenario starts in IDLE.
  task automatic drain();
    for (int k = 0; k < 20 && (m_busy || m_have); k++) step(0, 0, 0, 12'h0, 0);
  endtask

  task automatic waitBusy();
    for (int k = 0; k < 20 && !m_busy; k++) step(1, 0, 0, 12'h0, 0);
  endtask

  initial begin
    imem.ack   = 1'b0;
    imem.rdata = '0;
    lat = 0;
    wc  = 0;

    // Reset values
    step(0, 0, 0, 12'h0, 1);
    step(1, 0, 0, 12'h0, 1);

    // Zero-wait streaming: instr_pc 0,1,2,3 with a valid every second cycle
    lat = 0;
    for (int k = 0; k < 9; k++) step(1, 0, 0, 12'h0, 0);

    // Hold under stall for 5 cycles, then resume at pc+1
    for (int k = 0; k < 4 && !m_have; k++) step(1, 0, 0, 12'h0, 0);
    for (int k = 0; k < 5; k++) step(1, 1, 0, 12'h0, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 12'h0, 0);

    // Redirect to 0x100 in the second wait cycle of a 4-cycle memory
    drain();
    lat = 4;
    waitBusy();
    step(1, 0, 0, 12'h0, 0);
    step(1, 0, 1, 12'h100, 0);
    for (int k = 0; k < 10; k++) step(1, 0, 0, 12'h0, 0);

    // Redirect on the same cycle as the ack
    drain();
    lat = 0;
    waitBusy();
    step(1, 0, 1, 12'h200, 0);
    for (int k = 0; k < 5; k++) step(1, 0, 0, 12'h0, 0);

    // PC wrap from 0xFFF to 0x000
    drain();
    step(0, 0, 1, 12'hFFF, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 12'h0, 0);

    // Reset while a request is waiting, then with the ack arriving under reset
    drain();
    lat = 3;
    waitBusy();
    step(1, 0, 0, 12'h0, 0);
    step(1, 0, 0, 12'h0, 1);
    lat = 0;
    waitBusy();
    step(1, 0, 0, 12'h0, 1);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 12'h0, 0);

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      if (!m_busy) lat = int'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0,
           12'($urandom),
           $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
